// File: rtl/mem_rw_arbiter.sv
// Round-robin arbiter sharing one byte-memory R/W controller between clients A and B,
// with command bounds checking, completion timeout and a held error report.
module mem_rw_arbiter #(
    parameter int MEM_DEPTH = 64,
    parameter int TIMEOUT   = 31
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_a_req,
    input  logic       i_a_wr,
    input  logic [5:0] i_a_addr,
    input  logic [3:0] i_a_num_b,
    output logic       o_a_gnt,
    output logic       o_a_done,
    input  logic       i_b_req,
    input  logic       i_b_wr,
    input  logic [5:0] i_b_addr,
    input  logic [3:0] i_b_num_b,
    output logic       o_b_gnt,
    output logic       o_b_done,
    output logic       o_mem_wr_req,
    output logic       o_mem_rd_req,
    output logic [5:0] o_mem_addr,
    output logic [3:0] o_mem_num_b,
    input  logic       i_mem_ack,
    input  logic       i_mem_done,
    output logic       o_err,
    output logic [2:0] o_err_code,
    output logic       o_err_src,
    input  logic       i_err_ack,
    output logic [1:0] o_dbg_state
);

    // Handshakes: a client holds i_x_req (with stable command fields) until it sees o_x_done
    // or an error naming it; o_mem_*_req is held until i_mem_ack is sampled high; i_mem_done
    // and i_err_ack are single-cycle strobes that are only honoured in the state expecting them.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam logic [6:0] DEPTH_LIM = 7'(MEM_DEPTH);
    localparam logic [4:0] TIMER_LIM = 5'(TIMEOUT);

    state_t     state, state_n;
    logic       last_gnt, last_gnt_n;
    logic       owner, owner_n;
    logic [4:0] timer, timer_n, timer_inc;

    logic       a_gnt_n, b_gnt_n, a_done_n, b_done_n;
    logic       wr_req_n, rd_req_n, err_n, err_src_n;
    logic [5:0] addr_n;
    logic [3:0] num_b_n;
    logic [2:0] err_code_n;

    logic       cand_a, cand_b, sel_b, sel_wr, sel_illegal;
    logic [5:0] sel_addr;
    logic [3:0] sel_num_b;
    logic [6:0] sel_end;
    logic       finish, raise;
    logic [2:0] raise_code;

    // A client whose done pulse is showing this cycle has not yet had a chance to
    // withdraw its finished command, so it must not be re-selected.
    assign cand_a      = i_a_req & ~o_a_done;
    assign cand_b      = i_b_req & ~o_b_done;
    assign sel_b       = cand_b & (~cand_a | ~last_gnt);
    assign sel_wr      = sel_b ? i_b_wr    : i_a_wr;
    assign sel_addr    = sel_b ? i_b_addr  : i_a_addr;
    assign sel_num_b   = sel_b ? i_b_num_b : i_a_num_b;
    assign sel_end     = {1'b0, sel_addr} + {3'b000, sel_num_b};
    assign sel_illegal = (sel_num_b == 4'd0) || (sel_end > DEPTH_LIM);
    assign timer_inc   = (timer == 5'h1f) ? timer : timer + 5'd1;
    assign o_dbg_state = state;

    always_comb begin
        state_n    = state;
        last_gnt_n = last_gnt;
        owner_n    = owner;
        timer_n    = timer;
        a_gnt_n    = o_a_gnt;
        b_gnt_n    = o_b_gnt;
        a_done_n   = 1'b0;
        b_done_n   = 1'b0;
        wr_req_n   = o_mem_wr_req;
        rd_req_n   = o_mem_rd_req;
        addr_n     = o_mem_addr;
        num_b_n    = o_mem_num_b;
        err_n      = o_err;
        err_code_n = o_err_code;
        err_src_n  = o_err_src;
        finish     = 1'b0;
        raise      = 1'b0;
        raise_code = 3'd0;

        case (state)
            S_IDLE: begin
                if (cand_a || cand_b) begin
                    last_gnt_n = sel_b;
                    owner_n    = sel_b;
                    addr_n     = sel_addr;
                    num_b_n    = sel_num_b;
                    timer_n    = 5'd0;
                    if (sel_illegal) begin
                        raise      = 1'b1;
                        raise_code = 3'd3;
                    end else begin
                        state_n  = S_REQ;
                        a_gnt_n  = ~sel_b;
                        b_gnt_n  = sel_b;
                        wr_req_n = sel_wr;
                        rd_req_n = ~sel_wr;
                    end
                end
            end
            S_REQ: begin
                if (i_mem_ack && i_mem_done) begin
                    finish = 1'b1;
                end else if (i_mem_ack) begin
                    state_n  = S_XFER;
                    wr_req_n = 1'b0;
                    rd_req_n = 1'b0;
                    timer_n  = 5'd0;
                end else if (timer_inc == TIMER_LIM) begin
                    raise      = 1'b1;
                    raise_code = 3'd1;
                end else begin
                    timer_n = timer_inc;
                end
            end
            S_XFER: begin
                if (i_mem_done) begin
                    finish = 1'b1;
                end else if (timer_inc == TIMER_LIM) begin
                    raise      = 1'b1;
                    raise_code = 3'd2;
                end else begin
                    timer_n = timer_inc;
                end
            end
            S_ERR: begin
                if (i_err_ack) begin
                    state_n    = S_IDLE;
                    err_n      = 1'b0;
                    err_code_n = 3'd0;
                    timer_n    = 5'd0;
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (finish) begin
            state_n  = S_IDLE;
            a_done_n = ~owner;
            b_done_n = owner;
            a_gnt_n  = 1'b0;
            b_gnt_n  = 1'b0;
            wr_req_n = 1'b0;
            rd_req_n = 1'b0;
            timer_n  = 5'd0;
        end

        // The error source is the client just selected in IDLE, otherwise the current owner.
        if (raise) begin
            state_n    = S_ERR;
            err_n      = 1'b1;
            err_code_n = raise_code;
            err_src_n  = owner_n;
            a_gnt_n    = 1'b0;
            b_gnt_n    = 1'b0;
            wr_req_n   = 1'b0;
            rd_req_n   = 1'b0;
            timer_n    = 5'd0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state        <= S_IDLE;
            last_gnt     <= 1'b1;
            owner        <= 1'b0;
            timer        <= 5'd0;
            o_a_gnt      <= 1'b0;
            o_b_gnt      <= 1'b0;
            o_a_done     <= 1'b0;
            o_b_done     <= 1'b0;
            o_mem_wr_req <= 1'b0;
            o_mem_rd_req <= 1'b0;
            o_mem_addr   <= 6'd0;
            o_mem_num_b  <= 4'd0;
            o_err        <= 1'b0;
            o_err_code   <= 3'd0;
            o_err_src    <= 1'b0;
        end else begin
            state        <= state_n;
            last_gnt     <= last_gnt_n;
            owner        <= owner_n;
            timer        <= timer_n;
            o_a_gnt      <= a_gnt_n;
            o_b_gnt      <= b_gnt_n;
            o_a_done     <= a_done_n;
            o_b_done     <= b_done_n;
            o_mem_wr_req <= wr_req_n;
            o_mem_rd_req <= rd_req_n;
            o_mem_addr   <= addr_n;
            o_mem_num_b  <= num_b_n;
            o_err        <= err_n;
            o_err_code   <= err_code_n;
            o_err_src    <= err_src_n;
        end
    end

endmodule

// File: tb/tb_mem_rw_arbiter.sv
// Self-checking bench for mem_rw_arbiter: directed vector table, multi-cycle corner
// sequences, and randomized two-client traffic against a transaction-level model.
module tb_mem_rw_arbiter;
    localparam int DEPTH = 64;
    localparam int TOUT  = 31;

    logic       clk;
    logic       i_reset;
    logic       i_a_req, i_a_wr, i_b_req, i_b_wr;
    logic [5:0] i_a_addr, i_b_addr;
    logic [3:0] i_a_num_b, i_b_num_b;
    logic       o_a_gnt, o_a_done, o_b_gnt, o_b_done;
    logic       o_mem_wr_req, o_mem_rd_req;
    logic [5:0] o_mem_addr;
    logic [3:0] o_mem_num_b;
    logic       i_mem_ack, i_mem_done;
    logic       o_err, o_err_src;
    logic [2:0] o_err_code;
    logic       i_err_ack;
    logic [1:0] o_dbg_state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         b;
        bit         wr;
        logic [5:0] addr;
        logic [3:0] nb;
        bit         exp_err;
        logic [2:0] exp_code;
    } vec_t;

    typedef struct {
        bit         wr;
        logic [5:0] addr;
        logic [3:0] nb;
    } cmd_t;

    logic [12:0] exp_q[$];
    vec_t        vecs[8];

    mem_rw_arbiter #(.MEM_DEPTH(DEPTH), .TIMEOUT(TOUT)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_a_req(i_a_req), .i_a_wr(i_a_wr), .i_a_addr(i_a_addr), .i_a_num_b(i_a_num_b),
        .o_a_gnt(o_a_gnt), .o_a_done(o_a_done),
        .i_b_req(i_b_req), .i_b_wr(i_b_wr), .i_b_addr(i_b_addr), .i_b_num_b(i_b_num_b),
        .o_b_gnt(o_b_gnt), .o_b_done(o_b_done),
        .o_mem_wr_req(o_mem_wr_req), .o_mem_rd_req(o_mem_rd_req),
        .o_mem_addr(o_mem_addr), .o_mem_num_b(o_mem_num_b),
        .i_mem_ack(i_mem_ack), .i_mem_done(i_mem_done),
        .o_err(o_err), .o_err_code(o_err_code), .o_err_src(o_err_src),
        .i_err_ack(i_err_ack), .o_dbg_state(o_dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        i_a_req = 0; i_a_wr = 0; i_a_addr = 0; i_a_num_b = 0;
        i_b_req = 0; i_b_wr = 0; i_b_addr = 0; i_b_num_b = 0;
        i_mem_ack = 0; i_mem_done = 0; i_err_ack = 0;
    endtask

    task automatic apply_reset();
        i_reset = 1'b0;
        idle_inputs();
        step();
        step();
        i_reset = 1'b1;
    endtask

    task automatic set_client(input bit b, input bit req, input bit wr,
                              input logic [5:0] addr, input logic [3:0] nb);
        if (b) begin
            i_b_req = req; i_b_wr = wr; i_b_addr = addr; i_b_num_b = nb;
        end else begin
            i_a_req = req; i_a_wr = wr; i_a_addr = addr; i_a_num_b = nb;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"},  {30'd0, o_a_gnt, o_b_gnt}, 0);
        check({tag, "_done"}, {30'd0, o_a_done, o_b_done}, 0);
        check({tag, "_req"},  {30'd0, o_mem_wr_req, o_mem_rd_req}, 0);
        check({tag, "_addr"}, {22'd0, o_mem_addr, o_mem_num_b}, 0);
        check({tag, "_err"},  {27'd0, o_err, o_err_code, o_err_src}, 0);
        check({tag, "_state"}, {30'd0, o_dbg_state}, 0);
    endtask

    // driver: one table entry from a single client, with a fixed 2-cycle ack delay
    task automatic run_vec(input int idx, input vec_t v);
        string t;
        t = $sformatf("vec%0d", idx);
        set_client(v.b, 1, v.wr, v.addr, v.nb);
        step();
        if (!v.exp_err) begin
            check({t, "_gnt"}, {30'd0, o_a_gnt, o_b_gnt}, v.b ? 1 : 2);
            check({t, "_dir"}, {30'd0, o_mem_wr_req, o_mem_rd_req}, v.wr ? 2 : 1);
            check({t, "_addr"}, {26'd0, o_mem_addr}, {26'd0, v.addr});
            check({t, "_nb"}, {28'd0, o_mem_num_b}, {28'd0, v.nb});
            check({t, "_noerr"}, {31'd0, o_err}, 0);
            step();
            step();
            check({t, "_req_held"}, {31'd0, o_mem_wr_req | o_mem_rd_req}, 1);
            i_mem_ack = 1;
            step();
            i_mem_ack = 0;
            check({t, "_req_drop"}, {31'd0, o_mem_wr_req | o_mem_rd_req}, 0);
            check({t, "_gnt_xfer"}, {30'd0, o_a_gnt, o_b_gnt}, v.b ? 1 : 2);
            i_mem_done = 1;
            step();
            i_mem_done = 0;
            check({t, "_done"}, {30'd0, o_a_done, o_b_done}, v.b ? 1 : 2);
            check({t, "_gnt_off"}, {30'd0, o_a_gnt, o_b_gnt}, 0);
            set_client(v.b, 0, 0, 0, 0);
            step();
            check({t, "_done_1cyc"}, {30'd0, o_a_done, o_b_done}, 0);
        end else begin
            check({t, "_err"}, {31'd0, o_err}, 1);
            check({t, "_code"}, {29'd0, o_err_code}, {29'd0, v.exp_code});
            check({t, "_src"}, {31'd0, o_err_src}, {31'd0, v.b});
            check({t, "_noreq"}, {29'd0, o_mem_wr_req, o_mem_rd_req, o_a_gnt | o_b_gnt}, 0);
            set_client(v.b, 0, 0, 0, 0);
            step();
            check({t, "_err_held"}, {28'd0, o_err, o_err_code}, {28'd0, 1'b1, v.exp_code});
            i_err_ack = 1;
            step();
            i_err_ack = 0;
            check({t, "_err_clr"}, {28'd0, o_err, o_err_code}, 0);
        end
    endtask

    task automatic compare_txn(input logic [12:0] obs);
        if (exp_q.size() == 0) check("txn_unexpected", {19'd0, obs}, 0);
        else check("txn", {19'd0, obs}, {19'd0, exp_q.pop_front()});
    endtask

    // Both clients keep a command pending until their queue runs out; expected service
    // order and outcome come from a round-robin model over whole commands.
    task automatic run_traffic(input int na, input int nb, input bit rnd);
        cmd_t qa[$], qb[$], c;
        int   ia, ib, ack_dly, done_dly, err_dly, cycles, done_cnt, legal_cnt;
        bit   model_last, pick_b, legal, in_xfer, prev_req, prev_err, cur_owner;
        bit   ack_sent, fin, req_now, err_rise;

        for (int k = 0; k < na; k++) begin
            if (rnd) c = '{wr: 1'($urandom_range(0, 1)), addr: 6'($urandom_range(0, 63)),
                           nb: 4'($urandom_range(0, 15))};
            else c = '{wr: 1'b1, addr: 6'(8 * k), nb: 4'd4};
            qa.push_back(c);
        end
        for (int k = 0; k < nb; k++) begin
            if (rnd) c = '{wr: 1'($urandom_range(0, 1)), addr: 6'($urandom_range(0, 63)),
                           nb: 4'($urandom_range(0, 15))};
            else c = '{wr: 1'b0, addr: 6'(32 + k), nb: 4'd8};
            qb.push_back(c);
        end

        // reference model: alternate while both have work, starting with A after reset
        exp_q.delete();
        model_last = 1'b1;
        legal_cnt  = 0;
        ia = 0; ib = 0;
        while (ia < na || ib < nb) begin
            pick_b = (ib < nb) && (ia >= na || model_last == 1'b0);
            c = pick_b ? qb[ib] : qa[ia];
            if (pick_b) ib++; else ia++;
            model_last = pick_b;
            legal = (c.nb != 0) && (int'(c.addr) + int'(c.nb) <= DEPTH);
            if (legal) legal_cnt++;
            exp_q.push_back({pick_b, legal ? c.wr : 1'b0, c.addr, c.nb, ~legal});
        end

        ia = 0; ib = 0; cycles = 0; done_cnt = 0;
        in_xfer = 0; prev_req = 0; prev_err = 0; cur_owner = 0; ack_sent = 0; fin = 0;
        ack_dly = $urandom_range(0, 3); done_dly = 0; err_dly = $urandom_range(0, 3);
        while (!fin && cycles < 3000) begin
            step();
            cycles++;
            check("one_gnt", {31'd0, o_a_gnt & o_b_gnt}, 0);
            req_now  = o_mem_wr_req | o_mem_rd_req;
            err_rise = o_err & ~prev_err;
            if (req_now && !prev_req) begin
                compare_txn({o_b_gnt, o_mem_wr_req, o_mem_addr, o_mem_num_b, 1'b0});
                cur_owner = o_b_gnt;
            end
            if (err_rise) begin
                compare_txn({o_err_src, 1'b0, o_mem_addr, o_mem_num_b, 1'b1});
                check("txn_code", {29'd0, o_err_code}, 3);
            end
            if (o_a_done || o_b_done) begin
                check("done_owner", {30'd0, o_a_done, o_b_done}, cur_owner ? 1 : 2);
                done_cnt++;
            end
            if (o_a_done || (err_rise && !o_err_src)) ia++;
            if (o_b_done || (err_rise && o_err_src)) ib++;
            prev_req = req_now;
            prev_err = o_err;

            i_a_req = (ia < na);
            if (ia < na) begin
                i_a_wr = qa[ia].wr; i_a_addr = qa[ia].addr; i_a_num_b = qa[ia].nb;
            end
            i_b_req = (ib < nb);
            if (ib < nb) begin
                i_b_wr = qb[ib].wr; i_b_addr = qb[ib].addr; i_b_num_b = qb[ib].nb;
            end

            // memory controller responder
            i_mem_ack = 0; i_mem_done = 0;
            if (in_xfer) begin
                if (done_dly == 0) begin
                    i_mem_done = 1; in_xfer = 0;
                end else done_dly--;
            end else if (req_now) begin
                if (ack_dly == 0) begin
                    i_mem_ack = 1;
                    if ($urandom_range(0, 3) == 0) i_mem_done = 1;
                    else begin
                        in_xfer = 1; done_dly = $urandom_range(0, 4);
                    end
                    ack_dly = $urandom_range(0, 3);
                end else ack_dly--;
            end

            i_err_ack = 0;
            if (!o_err) ack_sent = 0;
            else if (!ack_sent) begin
                if (err_dly == 0) begin
                    i_err_ack = 1; ack_sent = 1; err_dly = $urandom_range(0, 3);
                end else err_dly--;
            end

            fin = (ia == na) && (ib == nb) && !o_err && !o_a_gnt && !o_b_gnt;
        end
        idle_inputs();
        check("traffic_finished", {31'd0, fin}, 1);
        check("traffic_leftover", exp_q.size(), 0);
        check("traffic_done_cnt", done_cnt, legal_cnt);
    endtask

    initial begin
        int n;
        vecs[0] = '{b: 0, wr: 1, addr: 6'd5,  nb: 4'd4,  exp_err: 0, exp_code: 3'd0};
        vecs[1] = '{b: 1, wr: 0, addr: 6'd62, nb: 4'd3,  exp_err: 1, exp_code: 3'd3};
        vecs[2] = '{b: 1, wr: 0, addr: 6'd60, nb: 4'd4,  exp_err: 0, exp_code: 3'd0};
        vecs[3] = '{b: 0, wr: 1, addr: 6'd0,  nb: 4'd0,  exp_err: 1, exp_code: 3'd3};
        vecs[4] = '{b: 0, wr: 0, addr: 6'd63, nb: 4'd1,  exp_err: 0, exp_code: 3'd0};
        vecs[5] = '{b: 1, wr: 1, addr: 6'd63, nb: 4'd2,  exp_err: 1, exp_code: 3'd3};
        vecs[6] = '{b: 0, wr: 0, addr: 6'd0,  nb: 4'd15, exp_err: 0, exp_code: 3'd0};
        vecs[7] = '{b: 1, wr: 1, addr: 6'd50, nb: 4'd15, exp_err: 1, exp_code: 3'd3};

        apply_reset();
        step();
        check_reset_outputs("reset");

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // ack never arrives
        set_client(0, 1, 1, 6'd1, 4'd2);
        step();
        n = 0;
        while (o_mem_wr_req && !o_err && n < 100) begin
            n++;
            step();
        end
        check("ack_to_cycles", n, TOUT);
        check("ack_to_err", {28'd0, o_err, o_err_code}, {28'd0, 1'b1, 3'd1});
        check("ack_to_quiet", {29'd0, o_mem_wr_req, o_mem_rd_req, o_a_gnt}, 0);
        set_client(0, 0, 0, 0, 0);
        i_mem_done = 1;
        step();
        i_mem_done = 0;
        check("stray_done", {30'd0, o_a_done, o_b_done}, 0);
        check("stray_err_held", {31'd0, o_err}, 1);
        step();
        check("stray_done_late", {30'd0, o_a_done, o_b_done}, 0);
        i_err_ack = 1;
        step();
        i_err_ack = 0;
        check("ack_to_clear", {28'd0, o_err, o_err_code}, 0);

        // ack arrives, done never does
        set_client(0, 1, 0, 6'd10, 4'd3);
        step();
        i_mem_ack = 1;
        step();
        i_mem_ack = 0;
        n = 0;
        while (o_a_gnt && !o_err && n < 100) begin
            n++;
            step();
        end
        check("done_to_cycles", n, TOUT);
        check("done_to_err", {27'd0, o_err, o_err_code, o_err_src}, {27'd0, 1'b1, 3'd2, 1'b0});
        check("done_to_gnt", {31'd0, o_a_gnt}, 0);
        set_client(0, 0, 0, 0, 0);
        i_err_ack = 1;
        step();
        i_err_ack = 0;
        check("done_to_clear", {31'd0, o_err}, 0);

        // ack and done together
        set_client(0, 1, 1, 6'd20, 4'd6);
        step();
        i_mem_ack = 1;
        i_mem_done = 1;
        step();
        i_mem_ack = 0;
        i_mem_done = 0;
        check("same_cyc_done", {30'd0, o_a_done, o_b_done}, 2);
        check("same_cyc_quiet", {29'd0, o_a_gnt, o_mem_wr_req, o_mem_rd_req}, 0);
        set_client(0, 0, 0, 0, 0);
        step();
        check("same_cyc_single", {30'd0, o_a_done, o_dbg_state}, 0);

        // round-robin with both clients loaded, then random traffic
        apply_reset();
        run_traffic(3, 3, 0);
        apply_reset();
        run_traffic(12, 12, 1);

        // reset during a transfer owned by A, then both request: A must still win
        set_client(0, 1, 0, 6'd2, 4'd2);
        step();
        i_mem_ack = 1;
        step();
        i_mem_ack = 0;
        check("pre_reset_xfer", {31'd0, o_a_gnt}, 1);
        i_reset = 0;
        set_client(0, 0, 0, 0, 0);
        step();
        i_reset = 1;
        check_reset_outputs("midreset");
        step();
        check("midreset_no_done", {30'd0, o_a_done, o_b_done}, 0);
        run_traffic(1, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
